io_bus_arbiter: RTL and testbench

Sequences all accesses to the MSX I/O port space: centronics 0x90-0x97, VDP 0x98-0x9F, PSG 0xA0-0xA7 and PPI 0xA8-0xAF.
- Two requesters share one registered I/O bus: the Z80 (IORQ cycles) and a host port (bridge/save-state engine, req/ack handshake).
- Converts each Z80 I/O cycle into exactly one single-clock rd/wr strobe.
- Inserts per-device wait states via Z80 WAIT_n.
- Sits between the CPU core and the peripheral chip-selects.

---
 rtl/msx_io_pkg.sv | 40 ++++
 rtl/io_sync_edge.sv | 24 ++
 rtl/io_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msx_io_pkg.sv
// Shared constants and device decode for the MSX I/O bus arbiter.
// Maps a port address onto its per-device wait-state count.
package msx_io_pkg;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StCpuAcc   = 3'd1;
    localparam logic [2:0] StCpuHold  = 3'd2;
    localparam logic [2:0] StHostAcc  = 3'd3;
    localparam logic [2:0] StHostDone = 3'd4;

    localparam logic [7:0] CenBase = 8'h90;
    localparam logic [7:0] VdpBase = 8'h98;
    localparam logic [7:0] PsgBase = 8'hA0;
    localparam logic [7:0] PpiBase = 8'hA8;

    localparam logic [4:0] CenPrefix = CenBase[7:3];
    localparam logic [4:0] VdpPrefix = VdpBase[7:3];
    localparam logic [4:0] PsgPrefix = PsgBase[7:3];
    localparam logic [4:0] PpiPrefix = PpiBase[7:3];

    function automatic logic [3:0] dev_wait(
        input logic [7:0] addr,
        input logic [3:0] cen_w,
        input logic [3:0] vdp_w,
        input logic [3:0] psg_w,
        input logic [3:0] ppi_w,
        input logic [3:0] def_w
    );
        logic [3:0] w;
        case (addr[7:3])
            CenPrefix: w = cen_w;
            VdpPrefix: w = vdp_w;
            PsgPrefix: w = psg_w;
            PpiPrefix: w = ppi_w;
            default:   w = def_w;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus rising-edge detect
// on the synchronised value.
module io_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], d};
        end
    end

    assign q    = sync_q[1];
    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/io_bus_arbiter.sv
// Arbitrates Z80 IORQ cycles and a host req/ack port onto one registered I/O
// bus, issuing one strobe per access and stretching the Z80 with WAIT_n.
module io_bus_arbiter
    import msx_io_pkg::*;
#(
    parameter int unsigned VDP_WAIT = 4,
    parameter int unsigned PSG_WAIT = 1,
    parameter int unsigned PPI_WAIT = 0,
    parameter int unsigned CEN_WAIT = 0,
    parameter int unsigned DEF_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] cpu_addr,
    input  logic       cpu_iorq_n,
    input  logic       cpu_m1_n,
    input  logic       cpu_rd_n,
    input  logic       cpu_wr_n,
    input  logic [7:0] cpu_dout,
    output logic [7:0] cpu_din,
    output logic       cpu_wait_n,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       host_ack,
    output logic [7:0] io_addr,
    output logic [7:0] io_dout,
    output logic       io_rd,
    output logic       io_wr,
    input  logic [7:0] io_din
);

    if (VDP_WAIT > 15 || PSG_WAIT > 15 || PPI_WAIT > 15 || CEN_WAIT > 15 || DEF_WAIT > 15)
    begin : g_wait_range
        $error("io_bus_arbiter: wait-state parameters must be in 0..15");
    end

    localparam logic [3:0] CenW = 4'(CEN_WAIT);
    localparam logic [3:0] VdpW = 4'(VDP_WAIT);
    localparam logic [3:0] PsgW = 4'(PSG_WAIT);
    localparam logic [3:0] PpiW = 4'(PPI_WAIT);
    localparam logic [3:0] DefW = 4'(DEF_WAIT);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       is_rd_q, is_rd_d;
    logic [7:0] cpu_din_d, host_rdata_d, io_addr_d, io_dout_d;
    logic       cpu_wait_n_d, host_ack_d, io_rd_d, io_wr_d;
    logic       cpu_cyc, cyc_sync, cyc_rise, cpu_go;

    // Interrupt acknowledge (M1 low) is excluded here so it never starts an access.
    assign cpu_cyc = ~cpu_iorq_n & cpu_m1_n & (~cpu_rd_n | ~cpu_wr_n);

    io_sync_edge u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (cpu_cyc),
        .q       (cyc_sync),
        .rise    (cyc_rise)
    );

    assign cpu_go = cyc_rise | (pend_q & cyc_sync);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        is_rd_d      = is_rd_q;
        cpu_din_d    = cpu_din;
        host_rdata_d = host_rdata;
        io_addr_d    = io_addr;
        io_dout_d    = io_dout;
        cpu_wait_n_d = cpu_wait_n;
        host_ack_d   = 1'b0;
        io_rd_d      = 1'b0;
        io_wr_d      = 1'b0;
        case (state_q)
            StIdle: begin
                pend_d = 1'b0;
                if (cpu_go) begin
                    state_d      = StCpuAcc;
                    io_addr_d    = cpu_addr;
                    io_dout_d    = cpu_dout;
                    is_rd_d      = ~cpu_rd_n;
                    io_rd_d      = ~cpu_rd_n;
                    io_wr_d      = cpu_rd_n;
                    cnt_d        = dev_wait(cpu_addr, CenW, VdpW, PsgW, PpiW, DefW);
                    cpu_wait_n_d = 1'b0;
                end else if (pend_q) begin
                    // CPU abandoned its cycle while queued behind the host.
                    cpu_wait_n_d = 1'b1;
                end else if (host_req) begin
                    state_d   = StHostAcc;
                    io_addr_d = host_addr;
                    io_dout_d = host_wdata;
                    is_rd_d   = ~host_we;
                    io_rd_d   = ~host_we;
                    io_wr_d   = host_we;
                    cnt_d     = dev_wait(host_addr, CenW, VdpW, PsgW, PpiW, DefW);
                end
            end
            StCpuAcc: begin
                if (!cyc_sync) begin
                    state_d      = StIdle;
                    cpu_wait_n_d = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    if (is_rd_q) cpu_din_d = io_din;
                    state_d = StCpuHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCpuHold: begin
                // Release lands one cycle after capture so read data is stable first.
                cpu_wait_n_d = 1'b1;
                if (!cyc_sync) state_d = StIdle;
            end
            StHostAcc: begin
                if (cyc_rise) begin
                    pend_d       = 1'b1;
                    cpu_wait_n_d = 1'b0;
                end
                if (cnt_q == 4'd0) begin
                    if (is_rd_q) host_rdata_d = io_din;
                    state_d    = StHostDone;
                    host_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHostDone: begin
                if (cyc_rise) begin
                    pend_d       = 1'b1;
                    cpu_wait_n_d = 1'b0;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            pend_q     <= 1'b0;
            is_rd_q    <= 1'b0;
            cpu_din    <= 8'hFF;
            cpu_wait_n <= 1'b1;
            host_rdata <= 8'h00;
            host_ack   <= 1'b0;
            io_addr    <= 8'h00;
            io_dout    <= 8'h00;
            io_rd      <= 1'b0;
            io_wr      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            is_rd_q    <= is_rd_d;
            cpu_din    <= cpu_din_d;
            cpu_wait_n <= cpu_wait_n_d;
            host_rdata <= host_rdata_d;
            host_ack   <= host_ack_d;
            io_addr    <= io_addr_d;
            io_dout    <= io_dout_d;
            io_rd      <= io_rd_d;
            io_wr      <= io_wr_d;
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: drivers push expected bus strobes and
// completions, a monitor pops and compares them as the DUT presents them.
module tb_io_bus_arbiter;

    localparam int TbVdp = 4;
    localparam int TbPsg = 1;
    localparam int TbPpi = 0;
    localparam int TbCen = 2;
    localparam int TbDef = 3;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
    } strobe_t;

    typedef struct {
        bit         rd;
        logic [7:0] data;
        int         dur;
    } cpu_exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] cpu_addr;
    logic       cpu_iorq_n, cpu_m1_n, cpu_rd_n, cpu_wr_n;
    logic [7:0] cpu_dout, cpu_din;
    logic       cpu_wait_n;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic       host_ack;
    logic [7:0] io_addr, io_dout, io_din;
    logic       io_rd, io_wr;

    logic [7:0] pmem    [256];
    logic [7:0] mdl_mem [256];
    logic [7:0] last_host_rd;

    strobe_t    exp_strobe [$];
    cpu_exp_t   exp_cpu    [$];
    logic [7:0] exp_host   [$];

    int checks   = 0;
    int failures = 0;
    int low_cnt  = 0;
    bit prev_wait = 1'b1;

    assign io_din = pmem[io_addr];

    io_bus_arbiter #(
        .VDP_WAIT (TbVdp),
        .PSG_WAIT (TbPsg),
        .PPI_WAIT (TbPpi),
        .CEN_WAIT (TbCen),
        .DEF_WAIT (TbDef)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_addr   (cpu_addr),
        .cpu_iorq_n (cpu_iorq_n),
        .cpu_m1_n   (cpu_m1_n),
        .cpu_rd_n   (cpu_rd_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_dout   (cpu_dout),
        .cpu_din    (cpu_din),
        .cpu_wait_n (cpu_wait_n),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .io_addr    (io_addr),
        .io_dout    (io_dout),
        .io_rd      (io_rd),
        .io_wr      (io_wr),
        .io_din     (io_din)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string why);
        checks++;
        failures++;
        $display("FAIL %s actual=%s required=event", name, why);
    endtask

    function automatic int exp_wait(input logic [7:0] a);
        if (a >= 8'h90 && a <= 8'h97) return TbCen;
        if (a >= 8'h98 && a <= 8'h9F) return TbVdp;
        if (a >= 8'hA0 && a <= 8'hA7) return TbPsg;
        if (a >= 8'hA8 && a <= 8'hAF) return TbPpi;
        return TbDef;
    endfunction

    function automatic logic [7:0] pick_addr();
        if ($urandom_range(0, 9) < 8) return 8'h90 + 8'($urandom_range(0, 31));
        return 8'($urandom);
    endfunction

    task automatic check_reset(input string name);
        check(name, {cpu_din, cpu_wait_n, host_rdata, host_ack, io_addr, io_dout, io_rd, io_wr},
              {8'hFF, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
    endtask

    task automatic monitor();
        strobe_t  s;
        cpu_exp_t c;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                low_cnt   = 0;
                prev_wait = 1'b1;
            end else begin
                if (io_rd || io_wr) begin
                    if (exp_strobe.size() == 0) begin
                        fail("strobe", "unexpected");
                    end else begin
                        s = exp_strobe.pop_front();
                        check("strobe", {io_rd, io_wr, io_addr, io_wr ? io_dout : 8'h00},
                              {~s.wr, s.wr, s.addr, s.wr ? s.data : 8'h00});
                    end
                    if (io_wr) pmem[io_addr] = io_dout;
                end
                if (host_ack) begin
                    if (exp_host.size() == 0) fail("host_ack", "unexpected");
                    else check("host_rdata", host_rdata, exp_host.pop_front());
                end
                if (!cpu_wait_n) begin
                    low_cnt++;
                end else if (!prev_wait) begin
                    if (exp_cpu.size() == 0) begin
                        fail("cpu_done", "unexpected");
                    end else begin
                        c = exp_cpu.pop_front();
                        if (c.rd) check("cpu_din", cpu_din, c.data);
                        if (c.dur >= 0) check("wait_len", low_cnt, c.dur);
                    end
                    low_cnt = 0;
                end
                prev_wait = cpu_wait_n;
            end
        end
    endtask

    task automatic cpu_io(input bit rd, input logic [7:0] addr, input logic [7:0] data,
                          input int hold, input bit solo);
        int n;
        exp_strobe.push_back('{~rd, addr, data});
        if (!rd) mdl_mem[addr] = data;
        exp_cpu.push_back('{rd, mdl_mem[addr], solo ? exp_wait(addr) + 2 : -1});
        cpu_addr   = addr;
        cpu_dout   = data;
        cpu_iorq_n = 1'b0;
        cpu_rd_n   = ~rd;
        cpu_wr_n   = rd;
        n = 0;
        while (cpu_wait_n && n < 80) begin @(negedge clk); n++; end
        if (cpu_wait_n) fail("cpu_wait_assert", "timeout");
        n = 0;
        while (!cpu_wait_n && n < 80) begin @(negedge clk); n++; end
        if (!cpu_wait_n) fail("cpu_wait_release", "timeout");
        repeat (hold) @(negedge clk);
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic host_io(input bit we, input logic [7:0] addr, input logic [7:0] data,
                           input bit chk_lat, output bit wait_at_ack);
        int n;
        exp_strobe.push_back('{we, addr, data});
        if (we) mdl_mem[addr] = data;
        else last_host_rd = mdl_mem[addr];
        exp_host.push_back(last_host_rd);
        host_we    = we;
        host_addr  = addr;
        host_wdata = data;
        host_req   = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!host_ack && n < 120);
        wait_at_ack = cpu_wait_n;
        if (!host_ack) fail("host_ack_wait", "timeout");
        else if (chk_lat) check("host_latency", n, exp_wait(addr) + 2);
        host_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit wa;
        int bad;
        int n;
        logic [7:0] v;
        reset_n    = 1'b0;
        cpu_addr   = 8'h00;
        cpu_dout   = 8'h00;
        cpu_iorq_n = 1'b1;
        cpu_m1_n   = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 8'h00;
        host_wdata = 8'h00;
        last_host_rd = 8'h00;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mdl_mem[i] = v;
            pmem[i]    = v;
        end
        mdl_mem[8'hA8] = 8'h3C; pmem[8'hA8] = 8'h3C;
        mdl_mem[8'hA2] = 8'h77; pmem[8'hA2] = 8'h77;
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        check_reset("reset_values");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        cpu_io(1'b0, 8'h98, 8'h5A, 20, 1'b1);
        cpu_io(1'b1, 8'hA8, 8'h00, 0, 1'b1);
        host_io(1'b0, 8'hA2, 8'h00, 1'b1, wa);

        // CPU edge and host request land in the same IDLE cycle.
        fork
            cpu_io(1'b0, 8'h91, 8'hC3, 3, 1'b1);
            begin repeat (2) @(negedge clk); host_io(1'b1, 8'hA5, 8'h19, 1'b0, wa); end
        join

        // CPU read arrives while a long host write is in progress.
        fork
            host_io(1'b1, 8'h99, 8'h6E, 1'b1, wa);
            begin @(negedge clk); cpu_io(1'b1, 8'h99, 8'h00, 2, 1'b0); end
        join
        check("wait_at_host_ack", wa, 1'b0);

        cpu_iorq_n = 1'b0;
        cpu_m1_n   = 1'b0;
        bad = 0;
        repeat (10) begin @(negedge clk); if (!cpu_wait_n) bad++; end
        check("intack_wait", bad, 0);
        cpu_iorq_n = 1'b1;
        cpu_m1_n   = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) < 2)
                cpu_io(1'($urandom), pick_addr(), 8'($urandom), $urandom_range(0, 8), 1'b1);
            else
                host_io(1'($urandom), pick_addr(), 8'($urandom), 1'b1, wa);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        exp_strobe.push_back('{1'b1, 8'h9C, 8'hE1});
        mdl_mem[8'h9C] = 8'hE1;
        cpu_addr   = 8'h9C;
        cpu_dout   = 8'hE1;
        cpu_iorq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        n = 0;
        while (cpu_wait_n && n < 80) begin @(negedge clk); n++; end
        if (cpu_wait_n) fail("reset_acc_start", "timeout");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset("reset_mid_access");
        cpu_iorq_n = 1'b1;
        cpu_wr_n   = 1'b1;
        last_host_rd = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (!cpu_wait_n || host_ack || io_rd || io_wr) bad++;
        end
        check("post_reset_quiet", bad, 0);

        cpu_io(1'b1, 8'h9C, 8'h00, 1, 1'b1);
        host_io(1'b1, 8'h55, 8'h42, 1'b1, wa);
        host_io(1'b0, 8'h55, 8'h00, 1'b1, wa);
        repeat (5) @(negedge clk);
        check("drain", {8'(exp_strobe.size()), 8'(exp_cpu.size()), 8'(exp_host.size())}, 24'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
